// File: rtl/rocc_pkg.sv
// Shared RoCC definitions: custom opcodes, funct codes, field widths, issuer FSM states.
// Contents: OPC_CUSTOM0..3, funct_e, FUNCT_W/REG_W/XLEN/NUM_REGS, state_e, cmd_t, funct_legal().
// Imported by rocc_scoreboard and rocc_cmd_issuer.
package rocc_pkg;

  localparam int FUNCT_W  = 7;
  localparam int REG_W    = 5;
  localparam int XLEN     = 64;
  localparam int NUM_REGS = 1 << REG_W;

  localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
  localparam logic [6:0] OPC_CUSTOM1 = 7'h2B;
  localparam logic [6:0] OPC_CUSTOM2 = 7'h5B;
  localparam logic [6:0] OPC_CUSTOM3 = 7'h7B;

  typedef enum logic [FUNCT_W-1:0] {
    FN_CONFIG  = 7'd0,
    FN_LOAD    = 7'd1,
    FN_COMPUTE = 7'd2,
    FN_STORE   = 7'd3,
    FN_FLUSH   = 7'd4
  } funct_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Command held in the issue register. xs marks a loaded command so the
  // constant xs1/xs2 bits read as zero straight out of reset.
  typedef struct packed {
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rd;
    logic               xd;
    logic               xs;
    logic [6:0]         opcode;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
  } cmd_t;

  function automatic logic funct_legal(input logic [FUNCT_W-1:0] f, input int max_funct);
    return int'(f) <= max_funct;
  endfunction

endpackage

// File: rtl/rocc_scoreboard.sv
// Tracks destination registers awaiting a RoCC response and the count in flight.
// Ports: set (issue of an xd command), clr (response), two combinational pending queries, outstanding count.
// A clear only takes effect for a register that is actually pending; the count saturates at both ends.
module rocc_scoreboard
  import rocc_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_vld,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_vld,
  input  logic [REG_W-1:0] clr_rd,
  input  logic [REG_W-1:0] qry_a_rd,
  output logic             qry_a_hit,
  input  logic [REG_W-1:0] qry_b_rd,
  output logic             qry_b_hit,
  output logic [CNT_W-1:0] outstanding
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                clr_eff;

  assign clr_eff = clr_vld && pending_q[clr_rd];

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_vld) set_mask[set_rd] = 1'b1;
    if (clr_eff) clr_mask[clr_rd] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | set_mask;

    // Simultaneous issue and response cancel out.
    outstanding_d = outstanding_q;
    if (set_vld && !clr_eff && (outstanding_q != '1)) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!set_vld && clr_eff && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      outstanding_q <= '0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign qry_a_hit   = pending_q[qry_a_rd];
  assign qry_b_hit   = pending_q[qry_b_rd];
  assign outstanding = outstanding_q;

endmodule

// File: rtl/rocc_cmd_issuer.sv
// Issues host requests as RoCC custom commands and returns matched responses as one-cycle writebacks.
// Ports: req_* (host request), io_cmd_* (to accelerator), io_resp_* (from accelerator), wb_*, drain/drain_done, busy, sticky err_*.
// Config: define ROCC_ISSUER_WATCHDOG_EN to build the response watchdog driving err_timeout; otherwise err_timeout is 0.
module rocc_cmd_issuer
  import rocc_pkg::*;
#(
  parameter logic [6:0] OPCODE          = OPC_CUSTOM0,
  parameter int         MAX_OUTSTANDING = 4,
  parameter int         FUNCT_MAX       = 4,
  parameter int         TIMEOUT_CYCLES  = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FUNCT_W-1:0] req_funct,
  input  logic [REG_W-1:0]   req_rd,
  input  logic               req_xd,
  input  logic [XLEN-1:0]    req_rs1,
  input  logic [XLEN-1:0]    req_rs2,
  output logic               io_cmd_valid,
  input  logic               io_cmd_ready,
  output logic [FUNCT_W-1:0] io_cmd_bits_inst_funct,
  output logic [REG_W-1:0]   io_cmd_bits_inst_rs2,
  output logic [REG_W-1:0]   io_cmd_bits_inst_rs1,
  output logic               io_cmd_bits_inst_xd,
  output logic               io_cmd_bits_inst_xs1,
  output logic               io_cmd_bits_inst_xs2,
  output logic [REG_W-1:0]   io_cmd_bits_inst_rd,
  output logic [6:0]         io_cmd_bits_inst_opcode,
  output logic [XLEN-1:0]    io_cmd_bits_rs1,
  output logic [XLEN-1:0]    io_cmd_bits_rs2,
  input  logic               io_resp_valid,
  output logic               io_resp_ready,
  input  logic [REG_W-1:0]   io_resp_bits_rd,
  input  logic [XLEN-1:0]    io_resp_bits_data,
  output logic               wb_valid,
  output logic [REG_W-1:0]   wb_rd,
  output logic [XLEN-1:0]    wb_data,
  input  logic               drain,
  output logic               drain_done,
  output logic               busy,
  output logic               err_funct,
  output logic               err_unexpected,
  output logic               err_timeout
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic             cmd_vld_q, cmd_vld_d;
  logic             wb_vld_q, wb_vld_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             drain_done_q, drain_done_d;
  logic             err_funct_q, err_funct_d;
  logic             err_unexp_q, err_unexp_d;

  logic [CNT_W-1:0] outstanding;
  logic             req_pending, resp_hit;
  logic             accept, cmd_fire, resp_match;

  // Gating with reset keeps req_ready low for the whole time reset is held.
  assign req_ready = reset && (state_q == ST_IDLE) && !drain &&
                     !(req_xd && req_pending) &&
                     (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign io_resp_ready = reset;

  assign accept     = req_valid && req_ready;
  assign cmd_fire   = cmd_vld_q && io_cmd_ready;
  assign resp_match = io_resp_valid && resp_hit;

  rocc_scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
    .clk         (clock),
    .rst_n       (reset),
    .set_vld     (cmd_fire && cmd_q.xd),
    .set_rd      (cmd_q.rd),
    .clr_vld     (resp_match),
    .clr_rd      (io_resp_bits_rd),
    .qry_a_rd    (req_rd),
    .qry_a_hit   (req_pending),
    .qry_b_rd    (io_resp_bits_rd),
    .qry_b_hit   (resp_hit),
    .outstanding (outstanding)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_vld_d    = cmd_vld_q;
    drain_done_d = 1'b0;
    err_funct_d  = err_funct_q;
    err_unexp_d  = err_unexp_q | (io_resp_valid && !resp_hit);
    wb_vld_d     = resp_match;
    wb_rd_d      = resp_match ? io_resp_bits_rd   : wb_rd_q;
    wb_data_d    = resp_match ? io_resp_bits_data : wb_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (drain) begin
          state_d = ST_DRAIN;
        end else if (accept) begin
          if (funct_legal(req_funct, FUNCT_MAX)) begin
            state_d      = ST_ISSUE;
            cmd_vld_d    = 1'b1;
            cmd_d.funct  = req_funct;
            cmd_d.rd     = req_rd;
            cmd_d.xd     = req_xd;
            cmd_d.xs     = 1'b1;
            cmd_d.opcode = OPCODE;
            cmd_d.rs1    = req_rs1;
            cmd_d.rs2    = req_rs2;
          end else begin
            // Illegal funct is swallowed here and never reaches the accelerator.
            err_funct_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_fire) begin
          state_d   = ST_IDLE;
          cmd_vld_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (outstanding == '0) begin
          state_d      = ST_IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      cmd_vld_q    <= 1'b0;
      wb_vld_q     <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      drain_done_q <= 1'b0;
      err_funct_q  <= 1'b0;
      err_unexp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cmd_vld_q    <= cmd_vld_d;
      wb_vld_q     <= wb_vld_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      drain_done_q <= drain_done_d;
      err_funct_q  <= err_funct_d;
      err_unexp_q  <= err_unexp_d;
    end
  end

`ifdef ROCC_ISSUER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_timeout_q, err_timeout_d;

  // Counts cycles of silence while responses are owed; saturates at the limit.
  always_comb begin
    wdog_d = wdog_q;
    if ((outstanding == '0) || resp_match) begin
      wdog_d = '0;
    end else if (wdog_q != WD_W'(TIMEOUT_CYCLES)) begin
      wdog_d = wdog_q + 1'b1;
    end
    err_timeout_d = err_timeout_q | (wdog_d == WD_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign io_cmd_valid            = cmd_vld_q;
  assign io_cmd_bits_inst_funct  = cmd_q.funct;
  assign io_cmd_bits_inst_rs2    = '0;
  assign io_cmd_bits_inst_rs1    = '0;
  assign io_cmd_bits_inst_xd     = cmd_q.xd;
  assign io_cmd_bits_inst_xs1    = cmd_q.xs;
  assign io_cmd_bits_inst_xs2    = cmd_q.xs;
  assign io_cmd_bits_inst_rd     = cmd_q.rd;
  assign io_cmd_bits_inst_opcode = cmd_q.opcode;
  assign io_cmd_bits_rs1         = cmd_q.rs1;
  assign io_cmd_bits_rs2         = cmd_q.rs2;

  assign wb_valid       = wb_vld_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign drain_done     = drain_done_q;
  assign busy           = (state_q != ST_IDLE) || (outstanding != '0);
  assign err_funct      = err_funct_q;
  assign err_unexpected = err_unexp_q;

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Testbench for rocc_cmd_issuer: directed scenarios then randomized traffic against a transaction-level model.
// Model tracks owed registers, in-flight command, drain phase and sticky errors from the interface rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_rocc_cmd_issuer;
  import rocc_pkg::*;

  localparam int         MAXO = 4;
  localparam int         FMAX = 4;
  localparam int         TMO  = 16;
  localparam logic [6:0] OPC  = 7'h0B;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_xd = 1'b0, req_ready;
  logic [6:0]  req_funct = '0;
  logic [4:0]  req_rd = '0;
  logic [63:0] req_rs1 = '0, req_rs2 = '0;
  logic        io_cmd_valid, io_cmd_ready = 1'b0;
  logic [6:0]  c_funct, c_opcode;
  logic [4:0]  c_rs2, c_rs1, c_rd;
  logic        c_xd, c_xs1, c_xs2;
  logic [63:0] c_rs1_dat, c_rs2_dat;
  logic        io_resp_valid = 1'b0, io_resp_ready;
  logic [4:0]  io_resp_bits_rd = '0;
  logic [63:0] io_resp_bits_data = '0;
  logic        wb_valid, drain = 1'b0, drain_done, busy;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        err_funct, err_unexpected, err_timeout;

  always #5 clock = ~clock;

  rocc_cmd_issuer #(.OPCODE(OPC), .MAX_OUTSTANDING(MAXO), .FUNCT_MAX(FMAX), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct), .req_rd(req_rd),
    .req_xd(req_xd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_bits_inst_funct(c_funct), .io_cmd_bits_inst_rs2(c_rs2), .io_cmd_bits_inst_rs1(c_rs1),
    .io_cmd_bits_inst_xd(c_xd), .io_cmd_bits_inst_xs1(c_xs1), .io_cmd_bits_inst_xs2(c_xs2),
    .io_cmd_bits_inst_rd(c_rd), .io_cmd_bits_inst_opcode(c_opcode),
    .io_cmd_bits_rs1(c_rs1_dat), .io_cmd_bits_rs2(c_rs2_dat),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_bits_rd(io_resp_bits_rd), .io_resp_bits_data(io_resp_bits_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .drain(drain), .drain_done(drain_done), .busy(busy),
    .err_funct(err_funct), .err_unexpected(err_unexpected), .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0]  funct;
    logic [4:0]  rd;
    logic        xd;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } exp_cmd_t;

  exp_cmd_t    cmd_fifo[$];
  bit          pend[32];
  int          outst = 0;
  bit          draining = 0;
  bit          e_funct = 0, e_unexp = 0, e_to = 0;
  bit          wb_exp = 0, dd_exp = 0;
  logic [4:0]  wb_rd_exp = '0;
  logic [63:0] wb_data_exp = '0;
  int          dd_seen = 0;
`ifdef ROCC_ISSUER_WATCHDOG_EN
  int          wd = 0;
`endif

  always @(negedge clock) begin : monitor
    bit       inflight, ready_exp, matched;
    exp_cmd_t c;
    if (!reset) begin
      cmd_fifo.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      outst = 0; draining = 0; e_funct = 0; e_unexp = 0; e_to = 0; wb_exp = 0; dd_exp = 0;
`ifdef ROCC_ISSUER_WATCHDOG_EN
      wd = 0;
`endif
      check_eq("rst_req_ready", 64'(req_ready), 64'd0);
      check_eq("rst_cmd_valid", 64'(io_cmd_valid), 64'd0);
      check_eq("rst_cmd_inst", 64'({c_funct, c_rs2, c_rs1, c_xd, c_xs1, c_xs2, c_rd, c_opcode}), 64'd0);
      check_eq("rst_cmd_data", c_rs1_dat | c_rs2_dat, 64'd0);
      check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
      check_eq("rst_drain_done", 64'(drain_done), 64'd0);
      check_eq("rst_errors", 64'({err_funct, err_unexpected, err_timeout}), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
    end else begin
      inflight  = (cmd_fifo.size() != 0);
      ready_exp = !inflight && !draining && !drain && !(req_xd && pend[req_rd]) && (outst < MAXO);
      check_eq("req_ready", 64'(req_ready), 64'(ready_exp));
      check_eq("io_resp_ready", 64'(io_resp_ready), 64'd1);
      check_eq("busy", 64'(busy), 64'(inflight || draining || (outst != 0)));
      check_eq("err_funct", 64'(err_funct), 64'(e_funct));
      check_eq("err_unexpected", 64'(err_unexpected), 64'(e_unexp));
      check_eq("err_timeout", 64'(err_timeout), 64'(e_to));
      check_eq("wb_valid", 64'(wb_valid), 64'(wb_exp));
      if (wb_exp) begin
        check_eq("wb_rd", 64'(wb_rd), 64'(wb_rd_exp));
        check_eq("wb_data", wb_data, wb_data_exp);
      end
      check_eq("drain_done", 64'(drain_done), 64'(dd_exp));
      if (drain_done) dd_seen++;
      check_eq("cmd_valid", 64'(io_cmd_valid), 64'(inflight));
      if (inflight) begin
        c = cmd_fifo[0];
        check_eq("cmd_inst", 64'({c_funct, c_rs2, c_rs1, c_xd, c_xs1, c_xs2, c_rd, c_opcode}),
                 64'({c.funct, 5'd0, 5'd0, c.xd, 1'b1, 1'b1, c.rd, OPC}));
        check_eq("cmd_rs1", c_rs1_dat, c.rs1);
        check_eq("cmd_rs2", c_rs2_dat, c.rs2);
      end
      // Advance the model to what must hold after the coming rising edge.
      wb_exp  = 1'b0;
      dd_exp  = 1'b0;
      matched = io_resp_valid && pend[io_resp_bits_rd];
`ifdef ROCC_ISSUER_WATCHDOG_EN
      if (outst == 0 || matched) wd = 0;
      else if (wd < TMO) wd++;
      if (wd == TMO) e_to = 1'b1;
`endif
      if (draining) begin
        if (outst == 0) begin draining = 1'b0; dd_exp = 1'b1; end
      end else if (!inflight && drain) begin
        draining = 1'b1;
      end
      if (io_resp_valid) begin
        if (matched) begin
          pend[io_resp_bits_rd] = 1'b0;
          outst--;
          wb_exp = 1'b1; wb_rd_exp = io_resp_bits_rd; wb_data_exp = io_resp_bits_data;
        end else begin
          e_unexp = 1'b1;
        end
      end
      if (inflight && io_cmd_ready) begin
        c = cmd_fifo.pop_front();
        if (c.xd) begin pend[c.rd] = 1'b1; outst++; end
      end
      if (req_valid && ready_exp) begin
        if (int'(req_funct) > FMAX) e_funct = 1'b1;
        else cmd_fifo.push_back('{req_funct, req_rd, req_xd, req_rs1, req_rs2});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [6:0] f, input logic [4:0] rd, input logic xd,
                          input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    req_valid = 1'b1; req_funct = f; req_rd = rd; req_xd = xd; req_rs1 = a; req_rs2 = b;
    @(negedge clock);
    while (!req_ready && n < 100) begin
      step();
      @(negedge clock);
      n++;
    end
    if (n >= 100) check_eq("req_accept_timeout", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic send_resp(input logic [4:0] rd, input logic [63:0] d);
    io_resp_valid = 1'b1; io_resp_bits_rd = rd; io_resp_bits_data = d;
    step();
    io_resp_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cand[$];
    int n;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    step();

    // Single round trip
    io_cmd_ready = 1'b1;
    send_req(7'd2, 5'd5, 1'b1, 64'h1234, 64'h0);
    step();
    send_resp(5'd5, 64'hABCD);
    step();
    @(negedge clock);
    check_eq("roundtrip_idle_busy", 64'(busy), 64'd0);

    // Stall: accelerator not ready for 3 cycles
    step();
    io_cmd_ready = 1'b0;
    send_req(7'd1, 5'd6, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h55);
    repeat (3) step();
    io_cmd_ready = 1'b1;
    repeat (2) step();

    // Outstanding limit and per-register blocking
    for (int r = 1; r <= 4; r++) begin
      send_req(7'd3, 5'(r), 1'b1, 64'(r), 64'(r * 3));
    end
    step();
    req_valid = 1'b1; req_funct = 7'd1; req_rd = 5'd7; req_xd = 1'b1;
    @(negedge clock);
    check_eq("fifth_blocked", 64'(req_ready), 64'd0);
    step();
    send_resp(5'd3, 64'h33);
    @(negedge clock);
    check_eq("ready_after_resp", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    step();
    send_resp(5'd4, 64'h44);
    req_valid = 1'b1; req_funct = 7'd0; req_rd = 5'd2; req_xd = 1'b1;
    @(negedge clock);
    check_eq("pending_rd_blocked", 64'(req_ready), 64'd0);
    step();
    req_xd = 1'b0;
    @(negedge clock);
    check_eq("no_xd_not_blocked", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    step();
    send_resp(5'd1, 64'h11);
    send_resp(5'd2, 64'h22);
    send_resp(5'd7, 64'h77);

    // Illegal funct and unexpected response
    send_req(7'd7, 5'd3, 1'b1, 64'h1, 64'h2);
    @(negedge clock);
    check_eq("illegal_funct_err", 64'(err_funct), 64'd1);
    check_eq("illegal_funct_no_cmd", 64'(io_cmd_valid), 64'd0);
    step();
    send_resp(5'd9, 64'h99);
    @(negedge clock);
    check_eq("unexpected_err", 64'(err_unexpected), 64'd1);
    check_eq("unexpected_no_wb", 64'(wb_valid), 64'd0);
    step();

    // Drain with two outstanding
    send_req(7'd4, 5'd10, 1'b1, 64'hA, 64'hB);
    send_req(7'd4, 5'd11, 1'b1, 64'hC, 64'hD);
    step();
    drain = 1'b1;
    @(negedge clock);
    check_eq("drain_blocks_req", 64'(req_ready), 64'd0);
    step();
    step();
    drain = 1'b0;
    dd_seen = 0;
    send_resp(5'd10, 64'h1010);
    send_resp(5'd11, 64'h1111);
    repeat (8) step();
    check_eq("drain_done_pulses", 64'(dd_seen), 64'd1);

    // Watchdog: one response owed, silence
    send_req(7'd2, 5'd12, 1'b1, 64'h12, 64'h0);
    repeat (20) step();
    @(negedge clock);
`ifdef ROCC_ISSUER_WATCHDOG_EN
    check_eq("watchdog_fired", 64'(err_timeout), 64'd1);
`else
    check_eq("watchdog_absent", 64'(err_timeout), 64'd0);
`endif
    step();
    send_resp(5'd12, 64'h1212);

    // Reset mid-command: owed response afterwards is unexpected
    send_req(7'd1, 5'd14, 1'b1, 64'h14, 64'h0);
    step();
    io_cmd_ready = 1'b0;
    send_req(7'd1, 5'd15, 1'b1, 64'h15, 64'h0);
    step();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    io_cmd_ready = 1'b1;
    step();
    send_resp(5'd14, 64'h1414);
    @(negedge clock);
    check_eq("post_reset_unexpected", 64'(err_unexpected), 64'd1);
    check_eq("post_reset_no_cmd", 64'(io_cmd_valid), 64'd0);
    step();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_valid = ($urandom_range(1, 0) == 1);
      req_funct = ($urandom_range(7, 0) == 0) ? 7'($urandom_range(127, 5)) : 7'($urandom_range(4, 0));
      req_rd    = 5'($urandom_range(7, 0));
      req_xd    = ($urandom_range(3, 0) != 0);
      req_rs1   = {$urandom, $urandom};
      req_rs2   = {$urandom, $urandom};
      io_cmd_ready = ($urandom_range(9, 0) < 7);
      drain = ($urandom_range(63, 0) == 0);
      io_resp_valid = ($urandom_range(9, 0) < 3);
      cand.delete();
      foreach (pend[i]) if (pend[i]) cand.push_back(i);
      if (cand.size() != 0 && $urandom_range(7, 0) != 0)
        io_resp_bits_rd = 5'(cand[$urandom_range(cand.size() - 1, 0)]);
      else
        io_resp_bits_rd = 5'($urandom_range(31, 0));
      io_resp_bits_data = {$urandom, $urandom};
      step();
    end

    // Quiesce: answer everything still owed
    req_valid = 1'b0; drain = 1'b0; io_cmd_ready = 1'b1; io_resp_valid = 1'b0;
    n = 0;
    while ((outst != 0 || cmd_fifo.size() != 0 || draining) && n < 300) begin
      io_resp_valid = 1'b0;
      foreach (pend[i]) begin
        if (pend[i] && !io_resp_valid) begin
          io_resp_valid = 1'b1; io_resp_bits_rd = 5'(i); io_resp_bits_data = {$urandom, $urandom};
        end
      end
      step();
      n++;
    end
    io_resp_valid = 1'b0;
    repeat (2) step();
    @(negedge clock);
    check_eq("final_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
